// File: rtl/sram_loop_arbiter_if.sv
// rtl/sram_loop_arbiter_if.sv - requester and SRAM pin bundle for sram_loop_arbiter
//
// Purpose: groups the write/read request handshakes, loop control, status and
// SRAM pin signals into one interface.
//   slave  : the arbiter side (takes requests, drives the SRAM pins)
//   master : the environment side (recorder/DSP requesters, SRAM data return)
// Signals:
//   i_wr_req / i_wr_data / o_wr_ack       write requester handshake
//   i_rd_req / o_rd_ack / o_rd_data       read requester handshake
//   i_loop_len / i_clr                    loop length (0 = 2^ADDR_W), pointer clear
//   o_wr_ptr / o_rd_ptr / o_ovf / o_busy  status
//   o_sram_* / i_sram_dq                  SRAM pins (DQ tristate resolved at top level)

interface sram_loop_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              i_wr_req;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              i_rd_req;
    logic              o_rd_ack;
    logic [DATA_W-1:0] o_rd_data;
    logic [ADDR_W-1:0] i_loop_len;
    logic              i_clr;
    logic [ADDR_W-1:0] o_wr_ptr;
    logic [ADDR_W-1:0] o_rd_ptr;
    logic              o_ovf;
    logic              o_busy;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_dq;
    logic              o_sram_dq_oe;
    logic [DATA_W-1:0] i_sram_dq;
    logic              o_sram_we_n;
    logic              o_sram_oe_n;
    logic              o_sram_ce_n;

    modport slave (
        input  i_wr_req, i_wr_data, i_rd_req, i_loop_len, i_clr, i_sram_dq,
        output o_wr_ack, o_rd_ack, o_rd_data, o_wr_ptr, o_rd_ptr, o_ovf, o_busy,
               o_sram_addr, o_sram_dq, o_sram_dq_oe, o_sram_we_n, o_sram_oe_n,
               o_sram_ce_n
    );

    modport master (
        output i_wr_req, i_wr_data, i_rd_req, i_loop_len, i_clr, i_sram_dq,
        input  o_wr_ack, o_rd_ack, o_rd_data, o_wr_ptr, o_rd_ptr, o_ovf, o_busy,
               o_sram_addr, o_sram_dq, o_sram_dq_oe, o_sram_we_n, o_sram_oe_n,
               o_sram_ce_n
    );
endinterface

// File: rtl/sram_loop_arbiter.sv
// rtl/sram_loop_arbiter.sv - two-port looper arbiter for a single async SRAM
//
// Purpose: shares one async SRAM between a write requester (recorder) and a
// read requester (player). Each port keeps its own circular pointer over a
// programmable loop length. Every access is IDLE(grant) -> strobe for
// ACCESS_CYC cycles -> END(ack) -> IDLE.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset
//   bus    sram_loop_arbiter_if.slave (requests, status, SRAM pins)
// Parameters: ADDR_W (word address width), DATA_W (sample width),
//   ACCESS_CYC (strobe cycles per access, >= 1)
// Macro: SRAM_ARB_RR_EN selects round-robin arbitration; when undefined the
//   write port has fixed priority and no last-grant register exists.

module sram_loop_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int ACCESS_CYC = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sram_loop_arbiter_if.slave  bus
);

    localparam int              CNT_W    = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_END,
        S_RD,
        S_RD_END
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;
    // Set when a clear lands while an access is in flight (grant cycle included),
    // so that access's completion does not bump the freshly cleared pointer.
    logic              clr_seen_q, clr_seen_d;

    logic              grant_wr, grant_rd;
    logic              wr_ack, rd_ack;
    logic              wr_accept, rd_accept;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p,
                                                    input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] inc;
        inc = p + ADDR_W'(1);
        // len == 0 only matches at the natural wrap, where inc is already 0.
        return (inc == len) ? '0 : inc;
    endfunction

`ifdef SRAM_ARB_RR_EN
    // 1 = write was granted last; reset value favours the write port first.
    logic last_wr_q, last_wr_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

    always_comb begin
        last_wr_d = last_wr_q;
        if (grant_wr) begin
            last_wr_d = 1'b1;
        end else if (grant_rd) begin
            last_wr_d = 1'b0;
        end
    end
`endif

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == S_IDLE) begin
`ifdef SRAM_ARB_RR_EN
            if (wr_pend_q && rd_pend_q) begin
                grant_wr = !last_wr_q;
                grant_rd = last_wr_q;
            end else begin
                grant_wr = wr_pend_q;
                grant_rd = rd_pend_q;
            end
`else
            grant_wr = wr_pend_q;
            grant_rd = rd_pend_q && !wr_pend_q;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= '0;
            dq_q       <= '0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            clr_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            wr_data_q  <= wr_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            clr_seen_q <= clr_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_pend_d  = wr_pend_q;
        rd_pend_d  = rd_pend_q;
        wr_data_d  = wr_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        dq_d       = dq_q;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q;
        clr_seen_d = clr_seen_q | bus.i_clr;

        wr_ack = (state_q == S_WR_END);
        rd_ack = (state_q == S_RD_END);

        // The ack cycle frees the slot, so a pulse landing there is accepted.
        wr_accept = bus.i_wr_req && (!wr_pend_q || wr_ack);
        rd_accept = bus.i_rd_req && (!rd_pend_q || rd_ack);

        if (wr_accept) begin
            wr_pend_d = 1'b1;
            wr_data_d = bus.i_wr_data;
        end else if (wr_ack) begin
            wr_pend_d = 1'b0;
        end

        if (rd_accept) begin
            rd_pend_d = 1'b1;
        end else if (rd_ack) begin
            rd_pend_d = 1'b0;
        end

        if ((bus.i_wr_req && !wr_accept) || (bus.i_rd_req && !rd_accept)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                clr_seen_d = bus.i_clr;
                if (grant_wr) begin
                    state_d = S_WR;
                    addr_d  = wr_ptr_q;
                    dq_d    = wr_data_q;
                end else if (grant_rd) begin
                    state_d = S_RD;
                    addr_d  = rd_ptr_q;
                end
            end
            S_WR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WR_END;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_END: begin
                state_d = S_IDLE;
            end
            S_RD: begin
                if (cnt_q == CNT_LAST) begin
                    rd_data_d = bus.i_sram_dq;
                    state_d   = S_RD_END;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ack && !clr_seen_q) begin
                wr_ptr_d = ptr_next(wr_ptr_q, bus.i_loop_len);
            end
            if (rd_ack && !clr_seen_q) begin
                rd_ptr_d = ptr_next(rd_ptr_q, bus.i_loop_len);
            end
        end
    end

    assign bus.o_wr_ack     = wr_ack;
    assign bus.o_rd_ack     = rd_ack;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_wr_ptr     = wr_ptr_q;
    assign bus.o_rd_ptr     = rd_ptr_q;
    assign bus.o_ovf        = ovf_q;
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_dq    = dq_q;
    // WR_END keeps the chip selected and DQ driven so data/address hold past we_n rising.
    assign bus.o_sram_dq_oe = (state_q == S_WR) || (state_q == S_WR_END);
    assign bus.o_sram_we_n  = !(state_q == S_WR);
    assign bus.o_sram_oe_n  = !(state_q == S_RD);
    assign bus.o_sram_ce_n  = !((state_q == S_WR) || (state_q == S_WR_END) || (state_q == S_RD));

endmodule

// File: tb/tb_sram_loop_arbiter.sv
// tb/tb_sram_loop_arbiter.sv - self-checking bench for sram_loop_arbiter

module tb_sram_loop_arbiter;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 16;
    localparam int ACCESS_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_loop_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_loop_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYC(ACCESS_CYC)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // SRAM model: 256 words, writes captured while we_n is low.
    logic [15:0] mem [0:255];
    logic [19:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    logic        pre_en   = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_val  = '0;

    always @(negedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        if (!bus.o_sram_ce_n && !bus.o_sram_we_n && bus.o_sram_dq_oe) begin
            mem[bus.o_sram_addr[7:0]] <= bus.o_sram_dq;
            last_wr_addr <= bus.o_sram_addr;
            last_wr_data <= bus.o_sram_dq;
        end
        bus.i_sram_dq <= (!bus.o_sram_ce_n && !bus.o_sram_oe_n) ? mem[bus.o_sram_addr[7:0]] : 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0; bus.i_clr = 1'b0;
        bus.i_wr_data = '0;  bus.i_loop_len = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One isolated request; returns at the negedge of its ack cycle.
    task automatic txn(input bit is_rd, input logic [15:0] data,
                       output logic [19:0] addr_seen, output logic [15:0] rdata, output bit ok);
        @(posedge clk); #1;
        if (is_rd) bus.i_rd_req = 1'b1;
        else begin bus.i_wr_req = 1'b1; bus.i_wr_data = data; end
        @(posedge clk); #1;
        bus.i_rd_req = 1'b0; bus.i_wr_req = 1'b0;
        ok = 1'b0; addr_seen = '0; rdata = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (is_rd ? bus.o_rd_ack : bus.o_wr_ack) begin
                ok = 1'b1; addr_seen = bus.o_sram_addr; rdata = bus.o_rd_data;
            end
        end
    endtask

    // Pulse selected ports in cycle 0; report the cycle index of each ack (-1 = none).
    task automatic pair_run(input bit do_wr, input bit do_rd, output int wc, output int rc);
        @(posedge clk); #1;
        bus.i_wr_req = do_wr; bus.i_rd_req = do_rd; bus.i_wr_data = 16'hBEEF;
        @(negedge clk);
        @(posedge clk); #1;
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
        wc = -1; rc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.o_wr_ack && wc < 0) wc = c;
            if (bus.o_rd_ack && rc < 0) rc = c;
        end
    endtask

    function automatic logic [19:0] nxt(input logic [19:0] p, input int len);
        int m;
        m = (len == 0) ? (1 << 20) : len;
        return 20'((int'(p) + 1) % m);
    endfunction

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        logic [19:0] len;
        logic [19:0] exp_addr;
        logic [15:0] exp_rdata;
        logic [19:0] exp_wptr;
        logic [19:0] exp_rptr;
    } vec_t;

    vec_t tbl [10];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [19:0] a;
        logic [15:0] d;
        bit          ok;
        int          wc, rc, cnt;

        tbl[0] = '{0, 16'h1111, 20'd3, 20'd0, 16'h0,    20'd1, 20'd0};
        tbl[1] = '{0, 16'h2222, 20'd3, 20'd1, 16'h0,    20'd2, 20'd0};
        tbl[2] = '{0, 16'h3333, 20'd3, 20'd2, 16'h0,    20'd0, 20'd0};
        tbl[3] = '{0, 16'h4444, 20'd3, 20'd0, 16'h0,    20'd1, 20'd0};
        tbl[4] = '{0, 16'h5555, 20'd3, 20'd1, 16'h0,    20'd2, 20'd0};
        tbl[5] = '{1, 16'h0,    20'd3, 20'd0, 16'h4444, 20'd2, 20'd1};
        tbl[6] = '{1, 16'h0,    20'd3, 20'd1, 16'h5555, 20'd2, 20'd2};
        tbl[7] = '{1, 16'h0,    20'd3, 20'd2, 16'h3333, 20'd2, 20'd0};
        tbl[8] = '{0, 16'h6666, 20'd0, 20'd2, 16'h0,    20'd3, 20'd0};
        tbl[9] = '{1, 16'h0,    20'd0, 20'd0, 16'h4444, 20'd3, 20'd1};

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_we_n", bus.o_sram_we_n, 1);
        chk("rst_oe_n", bus.o_sram_oe_n, 1);
        chk("rst_ce_n", bus.o_sram_ce_n, 1);
        chk("rst_dq_oe", bus.o_sram_dq_oe, 0);
        chk("rst_addr", bus.o_sram_addr, 0);
        chk("rst_dq", bus.o_sram_dq, 0);
        chk("rst_rd_data", bus.o_rd_data, 0);
        chk("rst_ptrs", {bus.o_wr_ptr, bus.o_rd_ptr}, 0);
        chk("rst_ovf_busy", {bus.o_ovf, bus.o_busy}, 0);

        // Reset in the middle of a write
        @(posedge clk); #1 bus.i_wr_req = 1'b1; bus.i_wr_data = 16'h9999;
        @(posedge clk); #1 bus.i_wr_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (!bus.o_sram_we_n) ok = 1'b1;
        end
        chk("t1_reached_wr", ok, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_strobes", {bus.o_sram_we_n, bus.o_sram_oe_n, bus.o_sram_ce_n}, 3'b111);
        chk("t1_dq_oe", bus.o_sram_dq_oe, 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (bus.o_wr_ack) cnt++; end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (bus.o_wr_ack) cnt++; end
        chk("t1_no_ack", cnt, 0);
        chk("t1_ptrs", {bus.o_wr_ptr, bus.o_rd_ptr}, 0);
        chk("t1_busy", bus.o_busy, 0);

        // Cycle-exact single write
        @(posedge clk); #1 bus.i_wr_req = 1'b1; bus.i_wr_data = 16'hA5A5;
        @(negedge clk);
        chk("t2_c0_busy", bus.o_busy, 0);
        @(posedge clk); #1 bus.i_wr_req = 1'b0;
        @(negedge clk);
        chk("t2_c1_grant_strobes", {bus.o_sram_we_n, bus.o_sram_ce_n}, 2'b11);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            chk("t2_wr_we_ce", {bus.o_sram_we_n, bus.o_sram_ce_n, bus.o_sram_dq_oe}, 3'b001);
            chk("t2_wr_addr", bus.o_sram_addr, 0);
            chk("t2_wr_dq", bus.o_sram_dq, 16'hA5A5);
            chk("t2_wr_noack", bus.o_wr_ack, 0);
        end
        @(negedge clk);
        chk("t2_c4_we_n", bus.o_sram_we_n, 1);
        chk("t2_c4_ack", bus.o_wr_ack, 1);
        chk("t2_c4_hold", {bus.o_sram_dq_oe, bus.o_sram_dq}, {1'b1, 16'hA5A5});
        @(negedge clk);
        chk("t2_c5_ack_gone", bus.o_wr_ack, 0);
        chk("t2_c5_wr_ptr", bus.o_wr_ptr, 1);

        // Read of preloaded word
        @(posedge clk); #1 pre_addr = 8'd0; pre_val = 16'h1234; pre_en = 1'b1;
        @(posedge clk); #1 pre_en = 1'b0;
        bus.i_rd_req = 1'b1;
        @(posedge clk); #1 bus.i_rd_req = 1'b0;
        cnt = 0; ok = 1'b0; d = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!bus.o_sram_oe_n) cnt++;
            if (bus.o_rd_ack) begin ok = 1'b1; d = bus.o_rd_data; end
        end
        chk("t3_oe_cycles", cnt, ACCESS_CYC);
        chk("t3_ack", ok, 1);
        chk("t3_rd_data", d, 16'h1234);
        @(negedge clk);
        chk("t3_rd_ptr", bus.o_rd_ptr, 1);
        chk("t3_rd_data_hold", bus.o_rd_data, 16'h1234);

        // Table of transactions: loop wrap at length 3, then natural wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.i_loop_len = tbl[i].len;
            txn(tbl[i].is_rd, tbl[i].data, a, d, ok);
            chk($sformatf("tbl%0d_ack", i), ok, 1);
            chk($sformatf("tbl%0d_addr", i), a, tbl[i].exp_addr);
            if (tbl[i].is_rd) chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
            else              chk($sformatf("tbl%0d_wdata", i), last_wr_data, tbl[i].data);
            @(negedge clk);
            chk($sformatf("tbl%0d_wptr", i), bus.o_wr_ptr, tbl[i].exp_wptr);
            chk($sformatf("tbl%0d_rptr", i), bus.o_rd_ptr, tbl[i].exp_rptr);
        end

        // Simultaneous write and read
        do_reset();
        pair_run(1, 1, wc, rc);
        chk("t4_pair1_wr_cyc", wc, 4);
        chk("t4_pair1_rd_cyc", rc, 8);
`ifdef SRAM_ARB_RR_EN
        txn(0, 16'h0F0F, a, d, ok);
        chk("t4_lone_wr_ack", ok, 1);
        pair_run(1, 1, wc, rc);
        chk("t4_pair2_rd_cyc", rc, 4);
        chk("t4_pair2_wr_cyc", wc, 8);
`else
        pair_run(1, 1, wc, rc);
        chk("t4_pair2_wr_cyc", wc, 4);
        chk("t4_pair2_rd_cyc", rc, 8);
`endif

        // Back-to-back write pulses: second one is an overflow
        do_reset();
        @(posedge clk); #1 bus.i_wr_req = 1'b1; bus.i_wr_data = 16'h1111;
        @(posedge clk); #1 bus.i_wr_data = 16'h2222;
        @(posedge clk); #1 bus.i_wr_req = 1'b0;
        @(negedge clk);
        chk("t6_ovf_set", bus.o_ovf, 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.o_wr_ack) cnt++; end
        chk("t6_one_ack", cnt, 1);
        chk("t6_data_first", last_wr_data, 16'h1111);
        chk("t6_ovf_sticky", bus.o_ovf, 1);
        chk("t6_wr_ptr", bus.o_wr_ptr, 1);

        // Clear during an in-flight write
        txn(0, 16'h3C3C, a, d, ok);
        @(negedge clk);
        chk("clr_pre_wptr", bus.o_wr_ptr, 2);
        @(posedge clk); #1 bus.i_wr_req = 1'b1; bus.i_wr_data = 16'h7777;
        @(posedge clk); #1 bus.i_wr_req = 1'b0;
        @(posedge clk); #1 bus.i_clr = 1'b1;
        @(posedge clk); #1 bus.i_clr = 1'b0;
        @(negedge clk);
        chk("clr_wptr_now", bus.o_wr_ptr, 0);
        ok = 1'b0; a = '0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (bus.o_wr_ack) begin ok = 1'b1; a = bus.o_sram_addr; end
        end
        chk("clr_ack", ok, 1);
        chk("clr_latched_addr", a, 2);
        @(negedge clk);
        chk("clr_wptr_after", bus.o_wr_ptr, 0);

        // Randomized traffic against a transaction-level model
        begin : rand_phase
            logic [15:0] ref_mem [0:255];
            bit          ref_val [0:255];
            logic [19:0] rw, rr;
            logic [15:0] wd;
            bit          wo, ro;
            int          len;
            do_reset();
            len = $urandom_range(2, 12);
            bus.i_loop_len = 20'(len);
            for (int i = 0; i < 256; i++) begin ref_val[i] = 1'b0; ref_mem[i] = '0; end
            rw = '0; rr = '0; wo = 1'b0; ro = 1'b0; wd = '0;
            for (int cyc = 0; cyc < 840; cyc++) begin
                @(posedge clk); #1;
                bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
                if (cyc < 800) begin
                    if (!wo && $urandom_range(0, 3) == 0) begin
                        wd = 16'($urandom);
                        bus.i_wr_req = 1'b1; bus.i_wr_data = wd; wo = 1'b1;
                    end
                    if (!ro && $urandom_range(0, 3) == 0) begin
                        bus.i_rd_req = 1'b1; ro = 1'b1;
                    end
                end
                @(negedge clk);
                chk("rand_wptr", bus.o_wr_ptr, rw);
                chk("rand_rptr", bus.o_rd_ptr, rr);
                if (bus.o_wr_ack) begin
                    chk("rand_wr_expected", wo, 1);
                    chk("rand_wr_addr", last_wr_addr, rw);
                    chk("rand_wr_data", last_wr_data, wd);
                    ref_mem[rw[7:0]] = wd; ref_val[rw[7:0]] = 1'b1;
                    rw = nxt(rw, len); wo = 1'b0;
                end
                if (bus.o_rd_ack) begin
                    chk("rand_rd_expected", ro, 1);
                    if (ref_val[rr[7:0]]) chk("rand_rd_data", bus.o_rd_data, ref_mem[rr[7:0]]);
                    rr = nxt(rr, len); ro = 1'b0;
                end
            end
            chk("rand_drained", {wo, ro}, 0);
            chk("rand_no_ovf", bus.o_ovf, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
